sequence_generator: RTL
=======================

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: width of the pattern register (2..16).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port start, input, 1 bit: request to begin a transmission; sampled only in IDLE.
REQ-005 SHALL have port pattern, input, MAX_LEN bits: bit pattern to transmit; bit pat_len-1 goes first.
REQ-006 SHALL have port pat_len, input, $clog2(MAX_LEN)+1 bits: number of pattern bits to send.
REQ-007 SHALL have port repeat_cnt, input, 4 bits: extra repetitions; total sends = repeat_cnt+1.
REQ-008 SHALL have port data_out, output, 1 bit: serial bit stream, meaningful only while valid_out=1.
REQ-009 SHALL have port valid_out, output, 1 bit: high in each cycle data_out carries a pattern bit.
REQ-010 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the final bit of the final repetition.
REQ-012 SHALL have port state_out, output, 2 bits: current state encoding, for debug and board LEDs.

Function
REQ-013 SHALL implement four states, encoded IDLE=00, SHIFT=01, GAP=10, DONE=11; state_out SHALL equal the state register.
REQ-014 IDLE, start=1 at an edge: SHALL capture pattern, effective length, and repeat_cnt into internal registers; SHALL set bit index = length-1; next state SHIFT.
REQ-015 IDLE, start=0: SHALL remain in IDLE; captured registers SHALL hold.
REQ-016 Effective length SHALL be 1 when pat_len=0 and MAX_LEN when pat_len>MAX_LEN; otherwise pat_len.
REQ-017 SHIFT: data_out SHALL equal captured_pattern[bit index] and valid_out SHALL be 1; the bit index SHALL decrement each cycle.
REQ-018 SHIFT with bit index 0 and repetitions remaining > 0: SHALL decrement remaining, reload index to length-1, next state GAP.
REQ-019 SHIFT with bit index 0 and repetitions remaining = 0: next state DONE.
REQ-020 GAP SHALL last exactly one cycle, with data_out=0 and valid_out=0; next state SHIFT.
REQ-021 DONE SHALL last exactly one cycle, with done=1; next state IDLE.
REQ-022 Latency: the first pattern bit SHALL appear on data_out in the first cycle after the edge that samples start=1.
REQ-023 start SHALL be ignored in SHIFT, GAP and DONE; captured inputs SHALL NOT change during a transmission.
REQ-024 start=1 in the DONE cycle SHALL be ignored; a new transmission needs start=1 sampled in IDLE.
REQ-025 Changes on pattern, pat_len or repeat_cnt during a transmission SHALL NOT affect the bits being sent.
REQ-026 Outside SHIFT, data_out SHALL be 0 and valid_out SHALL be 0.
REQ-027 All outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.
REQ-028 Total busy cycles per transmission SHALL equal (repeat_cnt+1)*length + repeat_cnt + 1.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, state_out=00, data_out=0, valid_out=0, busy=0, done=0, and clear bit index, repeat counter and captured pattern, regardless of clock.
REQ-030 Reset asserted mid-transmission SHALL abort the transmission; after release, SHALL remain in IDLE until start=1 is sampled.
REQ-031 The first rising clk edge after reset deasserts SHALL be treated as a normal IDLE edge.

Verification
REQ-032 pattern=101 (low bits), pat_len=3, repeat_cnt=0, start pulse -> data_out 1,0,1 with valid_out=1 on cycles +1..+3; done=1 on cycle +4; IDLE on cycle +5.
REQ-033 Loopback: data_out gated by valid_out drives a 101 sequence detector; pattern 101, repeat_cnt=2 -> detector flags three times; GAP cycles are visible with valid_out=0; busy lasts 12 cycles.
REQ-034 pat_len=0, pattern bit0=1 -> exactly one bit (1) sent; pat_len=15 with MAX_LEN=8 -> 8 bits sent, MSB first.
REQ-035 Assert reset=0 on the second SHIFT cycle, asynchronously between edges -> all outputs are 0 and state_out=00 before the next edge; no done pulse.
REQ-036 start held high continuously with pattern changed mid-send -> the original pattern is sent intact; a new transmission begins only on the edge after DONE returns to IDLE.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends the captured pattern MSB-first, repeated
// repeat_cnt+1 times with a one-cycle gap between repetitions, then pulses done.
module sequence_generator #(
    parameter int unsigned MAX_LEN = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [MAX_LEN-1:0]       pattern,
    input  logic [$clog2(MAX_LEN):0] pat_len,
    input  logic [3:0]               repeat_cnt,
    output logic                     data_out,
    output logic                     valid_out,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               state_out
);

    localparam int unsigned IdxW = $clog2(MAX_LEN);
    localparam int unsigned LenW = IdxW + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StGap   = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [IdxW-1:0]    len_m1_q, len_m1_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [3:0]         rem_q, rem_d;
    logic [IdxW-1:0]    eff_len_m1;

    // Clamp the requested length into 1..MAX_LEN, kept as length-1.
    always_comb begin
        eff_len_m1 = '0;
        if (pat_len == '0) begin
            eff_len_m1 = '0;
        end else if (pat_len > LenW'(MAX_LEN)) begin
            eff_len_m1 = IdxW'(MAX_LEN - 1);
        end else begin
            eff_len_m1 = IdxW'(pat_len - LenW'(1));
        end
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_m1_d = len_m1_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    pat_d    = pattern;
                    len_m1_d = eff_len_m1;
                    idx_d    = eff_len_m1;
                    rem_d    = repeat_cnt;
                    state_d  = StShift;
                end
            end
            StShift: begin
                if (idx_q == '0) begin
                    if (rem_q != 4'd0) begin
                        rem_d   = rem_q - 4'd1;
                        idx_d   = len_m1_q;
                        state_d = StGap;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StGap:   state_d = StShift;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            pat_q    <= '0;
            len_m1_q <= '0;
            idx_q    <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_m1_q <= len_m1_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
        end
    end

    // Outputs depend on registers only; no input reaches an output combinationally.
    assign valid_out = (state_q == StShift);
    assign data_out  = valid_out & pat_q[idx_q];
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign state_out = state_q;

endmodule
